// File: rtl/decode_ctrl_stage.sv
// Decode-stage control unit: decodes op_code/funct into the control bundle and
// registers it at the ID/EX boundary, with stall/flush and MDU HI/LO hazard tracking.
module decode_ctrl_stage #(
  parameter int OP_BITS     = 6,
  parameter int FUNCT_BITS  = 6,
  parameter int MDU_LATENCY = 4,
  parameter int ENABLE_MDU  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  instr_valid_d,
  input  logic [OP_BITS-1:0]    op_code_d,
  input  logic [FUNCT_BITS-1:0] funct_d,
  input  logic                  stall_e,
  input  logic                  flush_e,
  output logic                  stall_d,
  output logic                  reg_write_e,
  output logic [1:0]            mem_to_reg_e,
  output logic                  mem_write_e,
  output logic [1:0]            alu_op_e,
  output logic                  alu_src_e,
  output logic [1:0]            reg_dst_e,
  output logic                  ext_op_e,
  output logic                  branch_e,
  output logic                  jump_e,
  output logic                  mdu_start_e,
  output logic [1:0]            hilo_rd_e,
  output logic                  illegal_e,
  output logic                  valid_e
);

  localparam int CNT_W = $clog2(MDU_LATENCY + 1);

  localparam logic [OP_BITS-1:0] OP_ROP  = OP_BITS'(6'b000000);
  localparam logic [OP_BITS-1:0] OP_LW   = OP_BITS'(6'b100011);
  localparam logic [OP_BITS-1:0] OP_SW   = OP_BITS'(6'b101011);
  localparam logic [OP_BITS-1:0] OP_BEQ  = OP_BITS'(6'b000100);
  localparam logic [OP_BITS-1:0] OP_ADDI = OP_BITS'(6'b001000);
  localparam logic [OP_BITS-1:0] OP_J    = OP_BITS'(6'b000010);
  localparam logic [OP_BITS-1:0] OP_JAL  = OP_BITS'(6'b000011);
  localparam logic [OP_BITS-1:0] OP_LWR  = OP_BITS'(6'b100110);

  localparam logic [FUNCT_BITS-1:0] F_SLL  = FUNCT_BITS'(6'b000000);
  localparam logic [FUNCT_BITS-1:0] F_JR   = FUNCT_BITS'(6'b001000);
  localparam logic [FUNCT_BITS-1:0] F_MFHI = FUNCT_BITS'(6'b010000);
  localparam logic [FUNCT_BITS-1:0] F_MFLO = FUNCT_BITS'(6'b010010);
  localparam logic [FUNCT_BITS-1:0] F_MULT = FUNCT_BITS'(6'b011000);
  localparam logic [FUNCT_BITS-1:0] F_DIV  = FUNCT_BITS'(6'b011010);
  localparam logic [FUNCT_BITS-1:0] F_ADD  = FUNCT_BITS'(6'b100000);
  localparam logic [FUNCT_BITS-1:0] F_SUB  = FUNCT_BITS'(6'b100010);
  localparam logic [FUNCT_BITS-1:0] F_AND  = FUNCT_BITS'(6'b100100);
  localparam logic [FUNCT_BITS-1:0] F_OR   = FUNCT_BITS'(6'b100101);
  localparam logic [FUNCT_BITS-1:0] F_SLT  = FUNCT_BITS'(6'b101010);

  typedef struct packed {
    logic       reg_write;
    logic [1:0] mem_to_reg;
    logic       mem_write;
    logic [1:0] alu_op;
    logic       alu_src;
    logic [1:0] reg_dst;
    logic       ext_op;
    logic       branch;
    logic       jump;
    logic       mdu_start;
    logic [1:0] hilo_rd;
    logic       illegal;
    logic       valid;
  } ctrl_t;

  ctrl_t            dec;
  ctrl_t            e_q;
  logic             legal;
  logic             is_mdu;
  logic             mdu_busy;
  logic             mdu_hazard;
  logic [CNT_W-1:0] mdu_cnt;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    dec    = '0;
    legal  = 1'b1;
    is_mdu = 1'b0;
    case (op_code_d)
      OP_ROP: begin
        dec.reg_write = 1'b1;
        dec.reg_dst   = 2'b01;
        dec.alu_op    = 2'b10;
        case (funct_d)
          F_ADD, F_SUB, F_AND, F_OR, F_SLT, F_JR, F_SLL: ;
          F_MULT, F_DIV: begin
            legal         = (ENABLE_MDU != 0);
            is_mdu        = (ENABLE_MDU != 0);
            dec.reg_write = 1'b0;
            dec.mdu_start = 1'b1;
          end
          F_MFHI: begin
            legal       = (ENABLE_MDU != 0);
            is_mdu      = (ENABLE_MDU != 0);
            dec.hilo_rd = 2'b01;
          end
          F_MFLO: begin
            legal       = (ENABLE_MDU != 0);
            is_mdu      = (ENABLE_MDU != 0);
            dec.hilo_rd = 2'b10;
          end
          default: legal = 1'b0;
        endcase
      end
      OP_LW: begin
        dec.reg_write  = 1'b1;
        dec.alu_src    = 1'b1;
        dec.ext_op     = 1'b1;
        dec.mem_to_reg = 2'b01;
      end
      OP_SW: begin
        dec.alu_src   = 1'b1;
        dec.ext_op    = 1'b1;
        dec.mem_write = 1'b1;
      end
      OP_BEQ: begin
        dec.branch = 1'b1;
        dec.ext_op = 1'b1;
        dec.alu_op = 2'b01;
      end
      OP_ADDI: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.ext_op    = 1'b1;
      end
      OP_J: dec.jump = 1'b1;
      OP_JAL: begin
        dec.jump       = 1'b1;
        dec.reg_write  = 1'b1;
        dec.reg_dst    = 2'b10;
        dec.mem_to_reg = 2'b10;
      end
      OP_LWR: begin
        dec.reg_write  = 1'b1;
        dec.reg_dst    = 2'b01;
        dec.mem_to_reg = 2'b01;
        dec.ext_op     = 1'b1;
      end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      dec         = '0;
      dec.illegal = 1'b1;
      is_mdu      = 1'b0;
    end
    dec.valid = 1'b1;
  end

  assign mdu_busy   = (mdu_cnt != '0);
  assign mdu_hazard = instr_valid_d & mdu_busy & is_mdu;
  assign stall_d    = stall_e | mdu_hazard;

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n)                            e_q <= '0;
    else if (flush_e)                      e_q <= '0;
    else if (stall_e)                      e_q <= e_q;
    else if (mdu_hazard || !instr_valid_d) e_q <= '0;
    else                                   e_q <= dec;
  end

  generate
    if (ENABLE_MDU != 0) begin : g_mdu
      logic issue_mdu;
      // The MDU keeps running through flushes; only a fresh issue reloads it.
      assign issue_mdu = instr_valid_d & ~stall_e & ~flush_e & ~mdu_hazard & dec.mdu_start;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         mdu_cnt <= '0;
        else if (issue_mdu) mdu_cnt <= CNT_W'(MDU_LATENCY);
        else if (mdu_busy)  mdu_cnt <= mdu_cnt - 1'b1;
      end
    end else begin : g_no_mdu
      assign mdu_cnt = '0;
    end
  endgenerate

  assign reg_write_e  = e_q.reg_write;
  assign mem_to_reg_e = e_q.mem_to_reg;
  assign mem_write_e  = e_q.mem_write;
  assign alu_op_e     = e_q.alu_op;
  assign alu_src_e    = e_q.alu_src;
  assign reg_dst_e    = e_q.reg_dst;
  assign ext_op_e     = e_q.ext_op;
  assign branch_e     = e_q.branch;
  assign jump_e       = e_q.jump;
  assign mdu_start_e  = e_q.mdu_start;
  assign hilo_rd_e    = e_q.hilo_rd;
  assign illegal_e    = e_q.illegal;
  assign valid_e      = e_q.valid;

endmodule

// File: tb/tb_decode_ctrl_stage.sv
// Scoreboard bench for decode_ctrl_stage: one instance with the MDU, one without,
// both checked against a behavioural model of the decode table and MDU timing.
module tb_decode_ctrl_stage;
  localparam int LAT = 4;

  localparam logic [5:0] OP_ROP = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
                         OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_J = 6'b000010,
                         OP_JAL = 6'b000011, OP_LWR = 6'b100110;
  localparam logic [5:0] F_SLL = 6'b000000, F_JR = 6'b001000, F_MFHI = 6'b010000,
                         F_MFLO = 6'b010010, F_MULT = 6'b011000, F_DIV = 6'b011010,
                         F_ADD = 6'b100000, F_SUB = 6'b100010, F_AND = 6'b100100,
                         F_OR = 6'b100101, F_SLT = 6'b101010;

  typedef struct packed {
    logic       rw;
    logic [1:0] m2r;
    logic       mw;
    logic [1:0] alu_op;
    logic       alu_src;
    logic [1:0] rdst;
    logic       ext;
    logic       br;
    logic       jmp;
    logic       ms;
    logic [1:0] hl;
    logic       ill;
    logic       vld;
  } bundle_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic v = 1'b0;
  logic [5:0] op = '0;
  logic [5:0] f = '0;
  logic st = 1'b0;
  logic fl = 1'b0;

  logic [1:0] sd, rw, mw, als, ext, br, jmp, ms, ill, vld;
  logic [1:0] m2r [2];
  logic [1:0] alo [2];
  logic [1:0] rdst [2];
  logic [1:0] hl [2];

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;
  int free_at = 0;
  bundle_t exp_e [2];
  bundle_t q0 [$];
  bundle_t q1 [$];

  always #5 clk = ~clk;

  decode_ctrl_stage #(.OP_BITS(6), .FUNCT_BITS(6), .MDU_LATENCY(LAT), .ENABLE_MDU(1)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid_d(v), .op_code_d(op), .funct_d(f),
    .stall_e(st), .flush_e(fl), .stall_d(sd[0]), .reg_write_e(rw[0]),
    .mem_to_reg_e(m2r[0]), .mem_write_e(mw[0]), .alu_op_e(alo[0]), .alu_src_e(als[0]),
    .reg_dst_e(rdst[0]), .ext_op_e(ext[0]), .branch_e(br[0]), .jump_e(jmp[0]),
    .mdu_start_e(ms[0]), .hilo_rd_e(hl[0]), .illegal_e(ill[0]), .valid_e(vld[0]));

  decode_ctrl_stage #(.OP_BITS(6), .FUNCT_BITS(6), .MDU_LATENCY(LAT), .ENABLE_MDU(0)) dut_nomdu (
    .clk(clk), .rst_n(rst_n), .instr_valid_d(v), .op_code_d(op), .funct_d(f),
    .stall_e(st), .flush_e(fl), .stall_d(sd[1]), .reg_write_e(rw[1]),
    .mem_to_reg_e(m2r[1]), .mem_write_e(mw[1]), .alu_op_e(alo[1]), .alu_src_e(als[1]),
    .reg_dst_e(rdst[1]), .ext_op_e(ext[1]), .branch_e(br[1]), .jump_e(jmp[1]),
    .mdu_start_e(ms[1]), .hilo_rd_e(hl[1]), .illegal_e(ill[1]), .valid_e(vld[1]));

  function automatic bundle_t act(input int i);
    bundle_t b;
    b = {rw[i], m2r[i], mw[i], alo[i], als[i], rdst[i], ext[i], br[i], jmp[i],
         ms[i], hl[i], ill[i], vld[i]};
    return b;
  endfunction

  task automatic check(input string name, input logic [31:0] a, input logic [31:0] e);
    n_checks++;
    if (a === e) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, a, e, $time);
  endtask

  function automatic bit mdu_funct(input logic [5:0] fn);
    return fn inside {F_MULT, F_DIV, F_MFHI, F_MFLO};
  endfunction

  // Reference decode: the instruction table written out as plain field settings.
  function automatic bundle_t model_decode(input logic [5:0] o, input logic [5:0] fn, input bit en);
    bundle_t b = '0;
    bit ok = 1'b1;
    if (o == OP_ROP) begin
      b.rw = 1; b.rdst = 2'b01; b.alu_op = 2'b10;
      if (fn inside {F_ADD, F_SUB, F_AND, F_OR, F_SLT, F_JR, F_SLL}) ok = 1;
      else if (en && (fn == F_MULT || fn == F_DIV)) begin b.rw = 0; b.ms = 1; end
      else if (en && fn == F_MFHI) b.hl = 2'b01;
      else if (en && fn == F_MFLO) b.hl = 2'b10;
      else ok = 0;
    end else if (o == OP_LW)   begin b.rw = 1; b.alu_src = 1; b.ext = 1; b.m2r = 2'b01; end
    else if (o == OP_SW)       begin b.alu_src = 1; b.ext = 1; b.mw = 1; end
    else if (o == OP_BEQ)      begin b.br = 1; b.ext = 1; b.alu_op = 2'b01; end
    else if (o == OP_ADDI)     begin b.rw = 1; b.alu_src = 1; b.ext = 1; end
    else if (o == OP_J)        b.jmp = 1;
    else if (o == OP_JAL)      begin b.jmp = 1; b.rw = 1; b.rdst = 2'b10; b.m2r = 2'b10; end
    else if (o == OP_LWR)      begin b.rw = 1; b.rdst = 2'b01; b.m2r = 2'b01; b.ext = 1; end
    else ok = 0;
    if (!ok) begin b = '0; b.ill = 1; end
    b.vld = 1;
    return b;
  endfunction

  // One decode cycle: drive inputs, check stall_d, then advance the model at the edge.
  task automatic step(input bit vv, input logic [5:0] o, input logic [5:0] fn,
                      input bit s, input bit fll, output bit stalled);
    bit haz [2];
    v = vv; op = o; f = fn; st = s; fl = fll;
    #1;
    for (int i = 0; i < 2; i++) begin
      haz[i] = (i == 0) && vv && (cyc < free_at) && (o == OP_ROP) && mdu_funct(fn);
      check($sformatf("stall_d[%0d]", i), 32'(sd[i]), 32'(s | haz[i]));
    end
    stalled = sd[0];
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (fll) exp_e[i] = '0;
      else if (s) exp_e[i] = exp_e[i];
      else if (haz[i] || !vv) exp_e[i] = '0;
      else begin
        exp_e[i] = model_decode(o, fn, i == 0);
        if (i == 0 && exp_e[i].ms) free_at = cyc + LAT + 1;
      end
    end
    cyc++;
    q0.push_back(exp_e[0]);
    q1.push_back(exp_e[1]);
    #1;
  endtask

  task automatic go(input bit vv, input logic [5:0] o, input logic [5:0] fn,
                    input bit s = 0, input bit fll = 0);
    bit dummy;
    step(vv, o, fn, s, fll, dummy);
  endtask

  // Monitor: compare every registered E bundle against the queued prediction.
  always @(negedge clk) begin
    if (q0.size() > 0 && q1.size() > 0) begin
      bundle_t e0, e1;
      e0 = q0.pop_front();
      e1 = q1.pop_front();
      check("e_bundle[0]", 32'(act(0)), 32'(e0));
      check("e_bundle[1]", 32'(act(1)), 32'(e1));
    end
  end

  task automatic do_reset();
    v = 0; st = 0; fl = 0;
    #2 rst_n = 0;
    q0.delete(); q1.delete();
    exp_e[0] = '0; exp_e[1] = '0; free_at = 0;
    #1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("reset_bundle[%0d]", i), 32'(act(i)), 32'h0);
      check($sformatf("reset_stall_d[%0d]", i), 32'(sd[i]), 32'h0);
    end
    @(posedge clk);
    #2 rst_n = 1;
  endtask

  initial begin
    bit stalled;
    int stalls;
    logic [5:0] ops [9];
    logic [5:0] fns [12];
    ops = '{OP_ROP, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J, OP_JAL, OP_LWR, OP_ROP};
    fns = '{F_SLL, F_JR, F_MFHI, F_MFLO, F_MULT, F_DIV, F_ADD, F_SUB, F_AND, F_OR, F_SLT, 6'b111111};
    exp_e[0] = '0; exp_e[1] = '0;

    #1;
    for (int i = 0; i < 2; i++) check($sformatf("por_bundle[%0d]", i), 32'(act(i)), 32'h0);
    @(posedge clk);
    #2 rst_n = 1;

    // Decode sweep across the table.
    go(1, OP_LW, 6'h00);
    go(1, OP_SW, 6'h15);
    go(1, OP_BEQ, 6'h00);
    go(1, OP_ADDI, 6'h3f);
    go(1, OP_J, 6'h00);
    go(1, OP_JAL, 6'h00);
    go(1, OP_LWR, 6'h00);
    go(1, OP_ROP, F_ADD);
    go(1, OP_ROP, F_SLL);
    go(1, OP_ROP, F_JR);

    // SW held under stall_e, then flush with stall.
    go(1, OP_SW, 6'h00);
    for (int k = 0; k < 3; k++) go(1, OP_ADDI, 6'h00, 1, 0);
    go(1, OP_ADDI, 6'h00, 1, 1);
    go(0, OP_ROP, 6'h00);

    // MULT followed by a dependent MFLO: count the stall cycles.
    go(1, OP_ROP, F_MULT);
    stalls = 0;
    for (int k = 0; k < 20; k++) begin
      step(1, OP_ROP, F_MFLO, 0, 0, stalled);
      if (!stalled) break;
      stalls++;
    end
    check("mflo_stall_cycles", 32'(stalls), 32'(LAT));
    go(0, OP_ROP, 6'h00);
    go(1, OP_ROP, F_DIV);
    go(1, OP_ADDI, 6'h00);
    go(1, OP_LW, 6'h00);
    for (int k = 0; k < LAT; k++) go(0, OP_ROP, 6'h00);

    // Illegal encodings, including MULT on the MDU-less instance.
    go(1, 6'b111111, 6'h00);
    go(1, OP_ROP, 6'b000001);
    go(1, OP_ROP, F_MULT);
    for (int k = 0; k < LAT; k++) go(0, OP_ROP, 6'h00);

    // A flushed MULT never starts the MDU.
    go(1, OP_ROP, F_MULT, 0, 1);
    go(1, OP_ROP, F_MFHI);
    go(0, OP_ROP, 6'h00);

    // Reset in the middle of an MDU operation.
    go(1, OP_ROP, F_MULT);
    go(1, OP_ADDI, 6'h00);
    #1;
    check("pre_reset_valid_e", 32'(vld[0]), 32'(exp_e[0].vld));
    do_reset();
    go(1, OP_ROP, F_MFHI);
    go(1, OP_LW, 6'h00);

    // Randomised traffic.
    for (int k = 0; k < 600; k++) begin
      logic [5:0] o, fn;
      o  = ($urandom_range(0, 9) < 8) ? ops[$urandom_range(0, 8)] : 6'($urandom);
      fn = ($urandom_range(0, 9) < 8) ? fns[$urandom_range(0, 11)] : 6'($urandom);
      go($urandom_range(0, 9) < 8, o, fn, $urandom_range(0, 9) < 2, $urandom_range(0, 9) < 1);
      if (k == 300) do_reset();
    end

    go(0, OP_ROP, 6'h00);
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/decode_ctrl_stage.md
# decode_ctrl_stage

Registered decode-stage control unit for the pipelined MIPS core. Decodes `op_code`/`funct` into the full control bundle and registers it into the ID/EX boundary. Handles downstream stall and flush. Tracks a parametrised-latency multiply/divide unit (MDU) and raises a decode stall on HI/LO hazards. Every field has a defined value for every opcode; unknown encodings are flagged as illegal.

## Interface
Parameters:
- `OP_BITS`, 6, opcode width.
- `FUNCT_BITS`, 6, funct width.
- `MDU_LATENCY`, 4, MDU busy cycles after issue (≥1); counter width is `$clog2(MDU_LATENCY+1)`.
- `ENABLE_MDU`, 1, when 0, MULT/DIV/MFHI/MFLO decode as illegal and the MDU counter is tied to 0.

Ports:
- `clk`  in  1  the single clock; all state changes on its rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `instr_valid_d`  in  1  decode slot holds a real instruction.
- `op_code_d`  in  OP_BITS  opcode.
- `funct_d`  in  FUNCT_BITS  funct field, used when opcode is ROP.
- `stall_e`  in  1  hold the E-stage register.
- `flush_e`  in  1  load a bubble into the E-stage register.
- `stall_d`  out  1  combinational; hold fetch/decode. Equals `stall_e | mdu_hazard`.
- `reg_write_e`  out  1  register file write enable.
- `mem_to_reg_e`  out  2  00 ALU, 01 memory, 10 PC+4 (link).
- `mem_write_e`  out  1  data memory write enable.
- `alu_op_e`  out  2  00 add, 01 subtract, 10 decode funct.
- `alu_src_e`  out  1  1 selects the immediate.
- `reg_dst_e`  out  2  00 rt, 01 rd, 10 $31.
- `ext_op_e`  out  1  1 sign-extend the immediate.
- `branch_e`, `jump_e`  out  1 each  control-flow flags.
- `mdu_start_e`  out  1  MULT/DIV issued this cycle.
- `hilo_rd_e`  out  2  00 none, 01 HI, 10 LO.
- `illegal_e`  out  1  unknown encoding.
- `valid_e`  out  1  E slot holds a real instruction.

## Operation
Decode table. Fields not listed are 0.
- ROP: `reg_write`, `reg_dst`=01, `alu_op`=10.
- LW (100011): `reg_write`, `alu_src`, `ext_op`, `mem_to_reg`=01.
- SW (101011): `alu_src`, `ext_op`, `mem_write`.
- BEQ (000100): `branch`, `ext_op`, `alu_op`=01.
- ADDI (001000): `reg_write`, `alu_src`, `ext_op`.
- J (000010): `jump`.
- JAL (000011): `jump`, `reg_write`, `reg_dst`=10, `mem_to_reg`=10.
- LWR (100110): `reg_write`, `reg_dst`=01, `mem_to_reg`=01, `ext_op`.

MDU instructions, all under ROP:
- MULT (funct 011000) and DIV (funct 011010): `reg_write`=0, `mdu_start`=1.
- MFHI (funct 010000): `hilo_rd`=01.
- MFLO (funct 010010): `hilo_rd`=10.
- ROP with funct 000000 is a legal NOP-shift and decodes as ROP.

Illegal encodings:
- Any other opcode, or an ROP funct outside {add 100000, sub 100010, and 100100, or 100101, slt 101010, jr 001000, sll 000000, MDU set}.
- Result: all write/branch/jump fields 0, `illegal_e`=1, `valid_e`=1.

MDU tracker:
- `busy = (mdu_cnt != 0)`.
- `mdu_hazard = instr_valid_d & busy & (decoded MULT/DIV/MFHI/MFLO)`.
- Issue means an instruction is loaded into E with `stall_e`=0, `flush_e`=0, `mdu_hazard`=0.
- Issuing MULT/DIV loads `mdu_cnt` = MDU_LATENCY.
- Otherwise `mdu_cnt` decrements by 1 each cycle while nonzero, independent of `stall_e`.
- A running MDU operation is never cancelled by `flush_e`.

E-register update priority (highest first):
1. `rst_n`=0: all outputs 0.
2. `flush_e`: load a bubble (all fields 0, including `valid_e` and `illegal_e`).
3. `stall_e`: hold all fields.
4. `mdu_hazard`: load a bubble.
5. `instr_valid_d`=0: load a bubble.
6. Otherwise: load the decoded bundle with `valid_e`=1.

## Timing
- Reset: every `*_e` output is 0, `mdu_cnt`=0, `stall_d`=0. Reset takes effect immediately on `rst_n` falling, without waiting for `clk`.
- Reset mid-MDU clears `mdu_cnt`; no hazard persists after reset.
- Decode to E latency: 1 cycle. `stall_d` is same-cycle combinational.
- A dependent HI/LO or MDU instruction following MULT/DIV stalls for exactly MDU_LATENCY cycles, then issues.
- `busy` is based on the registered count. At `mdu_cnt`=1 the instruction still stalls; it issues the cycle the count reads 0.
- `flush_e` and `stall_e` both asserted: flush wins.
- `flush_e` on an MDU instruction in decode: the counter is not loaded.
- Non-MDU instructions issue freely while `busy`.

## Test plan
- Reset: assert `rst_n`=0 mid-cycle with `valid_e`=1 and `mdu_cnt`=3 -> all outputs 0 immediately and `mdu_cnt`=0; after release, LW (100011) issues -> next cycle `reg_write_e`=1, `mem_to_reg_e`=01, `alu_src_e`=1, `ext_op_e`=1.
- Full decode sweep: each opcode in the table, plus R-type add (100000) -> E fields match the table exactly. JAL -> `reg_dst_e`=10, `mem_to_reg_e`=10, `jump_e`=1.
- Stall and flush: present SW, then hold `stall_e`=1 for 3 cycles -> `mem_write_e` stays 1 and `stall_d`=1. Assert `flush_e` and `stall_e` together -> next cycle `valid_e`=0.
- MDU hazard (MDU_LATENCY=4): MULT at cycle 0, MFLO in decode at cycle 1 -> `stall_d`=1 on cycles 1–4; MFLO reaches E at cycle 6 with `hilo_rd_e`=10. ADDI issued during busy -> no stall.
- Illegal encodings: opcode 111111 -> `illegal_e`=1, `valid_e`=1, `reg_write_e`=0, `mem_write_e`=0. With `ENABLE_MDU`=0, MULT -> `illegal_e`=1 and `mdu_start_e`=0.
- Flushed MDU: MULT in decode with `flush_e`=1 -> `mdu_cnt` stays 0, and a following MFHI issues with no stall.
